goertzel_tone_detector: RTL

- Downstream consumer of the goertzel block. Takes each finished block's power result (IEEE-754 binary64) plus its ready strobe and decides tone present/absent.
- Decision uses on/off thresholds with hysteresis, consecutive-block debounce, and a watchdog for a stalled goertzel.
- Runs on the 130 MHz system clock only. Outputs feed control/status logic.

---
 rtl/goertzel_tone_detector.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/goertzel_tone_detector.sv
// Tone present/absent decision on goertzel block power with hysteresis, debounce and stall watchdog.
// Optional peak-power hold is built when GOERTZEL_TONE_PEAK_HOLD_EN is defined.
module goertzel_tone_detector #(
  parameter logic [63:0] ON_THRESH      = 64'h40C3880000000000,
  parameter logic [63:0] OFF_THRESH     = 64'h40B3880000000000,
  parameter int unsigned ON_COUNT       = 3,
  parameter int unsigned OFF_COUNT      = 3,
  parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ready,
  input  logic [63:0] power,
  output logic        tone_present,
  output logic        tone_rise,
  output logic        tone_fall,
  output logic        stale,
  output logic [15:0] block_count,
  output logic [63:0] peak_power
);

  localparam int unsigned     WD_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES);
  localparam logic [15:0]     ON_N   = 16'(ON_COUNT);
  localparam logic [15:0]     OFF_N  = 16'(OFF_COUNT);

  typedef enum logic [1:0] {ABSENT, ARMING, PRESENT, RELEASING} state_t;
  typedef enum logic [1:0] {CLS_LOW, CLS_MID, CLS_HIGH} cls_t;

  state_t          state, next_state;
  logic [15:0]     hcnt, hcnt_next, lcnt, lcnt_next;
  logic            ready_q;
  logic            blk_evt;
  logic            is_nan;
  logic [62:0]     mag;
  cls_t            cls_d, cls_q;
  logic            cls_valid;
  logic [WD_W-1:0] wd, wd_next;
  logic            timeout;
  logic            tone_now, tone_next;

  // Edge detector tracks ready even in reset so a level held across reset is not a new block.
  always_ff @(posedge clock) begin
    ready_q <= ready;
  end

  assign blk_evt = ready & ~ready_q;
  assign is_nan  = (power[62:52] == 11'h7FF) && (power[51:0] != '0);
  assign mag     = power[63] ? '0 : power[62:0];

  always_comb begin
    cls_d = CLS_MID;
    if (mag > ON_THRESH[62:0])
      cls_d = CLS_HIGH;
    else if (mag < OFF_THRESH[62:0])
      cls_d = CLS_LOW;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cls_valid   <= 1'b0;
      cls_q       <= CLS_LOW;
      block_count <= '0;
    end else begin
      cls_valid <= blk_evt & ~is_nan;
      if (blk_evt && !is_nan) begin
        cls_q       <= cls_d;
        block_count <= block_count + 16'd1;
      end
    end
  end

  // Watchdog: stale and the forced release land on the same edge.
  always_comb begin
    if (blk_evt)
      wd_next = '0;
    else if (wd == WD_MAX)
      wd_next = wd;
    else
      wd_next = wd + WD_W'(1);
  end

  assign timeout = (wd_next == WD_MAX);

  always_ff @(posedge clock) begin
    if (reset) begin
      wd    <= '0;
      stale <= 1'b0;
    end else begin
      wd    <= wd_next;
      stale <= timeout;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ABSENT;
      hcnt  <= '0;
      lcnt  <= '0;
    end else begin
      state <= next_state;
      hcnt  <= hcnt_next;
      lcnt  <= lcnt_next;
    end
  end

  always_comb begin
    next_state = state;
    hcnt_next  = hcnt;
    lcnt_next  = lcnt;
    if (timeout) begin
      next_state = ABSENT;
      hcnt_next  = '0;
      lcnt_next  = '0;
    end else if (cls_valid) begin
      case (state)
        ABSENT: begin
          if (cls_q == CLS_HIGH) begin
            if (ON_N == 16'd1) begin
              next_state = PRESENT;
            end else begin
              next_state = ARMING;
              hcnt_next  = 16'd1;
            end
          end
        end
        ARMING: begin
          if (cls_q == CLS_HIGH) begin
            if (hcnt + 16'd1 == ON_N) begin
              next_state = PRESENT;
              hcnt_next  = '0;
            end else begin
              hcnt_next = hcnt + 16'd1;
            end
          end else begin
            next_state = ABSENT;
            hcnt_next  = '0;
          end
        end
        PRESENT: begin
          if (cls_q == CLS_LOW) begin
            if (OFF_N == 16'd1) begin
              next_state = ABSENT;
            end else begin
              next_state = RELEASING;
              lcnt_next  = 16'd1;
            end
          end
        end
        RELEASING: begin
          if (cls_q == CLS_LOW) begin
            if (lcnt + 16'd1 == OFF_N) begin
              next_state = ABSENT;
              lcnt_next  = '0;
            end else begin
              lcnt_next = lcnt + 16'd1;
            end
          end else begin
            next_state = PRESENT;
            lcnt_next  = '0;
          end
        end
        default: begin
          next_state = ABSENT;
          hcnt_next  = '0;
          lcnt_next  = '0;
        end
      endcase
    end
  end

  always_comb begin
    tone_now  = (state == PRESENT) || (state == RELEASING);
    tone_next = (next_state == PRESENT) || (next_state == RELEASING);
  end

  assign tone_present = tone_now;

  always_ff @(posedge clock) begin
    if (reset) begin
      tone_rise <= 1'b0;
      tone_fall <= 1'b0;
    end else begin
      tone_rise <= tone_next & ~tone_now;
      tone_fall <= tone_now & ~tone_next;
    end
  end

`ifdef GOERTZEL_TONE_PEAK_HOLD_EN
  logic [62:0] cls_mag;
  logic [63:0] peak_q;
  logic        peak_load, peak_grow;

  always_ff @(posedge clock) begin
    if (reset)
      cls_mag <= '0;
    else if (blk_evt && !is_nan)
      cls_mag <= mag;
  end

  assign peak_load = cls_valid & ~tone_now & (next_state == PRESENT);
  assign peak_grow = cls_valid & tone_now & (cls_mag > peak_q[62:0]);

  always_ff @(posedge clock) begin
    if (reset)
      peak_q <= '0;
    else if (peak_load || peak_grow)
      peak_q <= {1'b0, cls_mag};
  end

  assign peak_power = peak_q;
`else
  assign peak_power = '0;
`endif

endmodule
